gate_truth_table_sequencer: RTL and testbench



---
 rtl/gate_truth_table_sequencer_pkg.sv | 21 ++
 rtl/gate_truth_table_sequencer_settle_timer.sv | 34 +++
 rtl/gate_truth_table_sequencer.sv | 127 ++++++++++++
 tb/tb_gate_truth_table_sequencer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/gate_truth_table_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Package     : tt_seq_defs
// Description : State encodings and sizing helper shared by the truth-table
//               sequencer and its settle timer.
// Revision    : 1.0 - initial release
// ============================================================================
package tt_seq_defs;

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_settle = 2'd1;
    localparam logic [1:0] c_st_sample = 2'd2;
    localparam logic [1:0] c_st_done   = 2'd3;

    // Number of input combinations for an n_in-input gate.
    function automatic int combos(input int n_in);
        return 1 << n_in;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gate_truth_table_sequencer_settle_timer.sv
`default_nettype none
// ============================================================================
// Module      : settle_timer
// Description : Hold counter for one input vector; flags expiry once the
//               count reaches SETTLE-1 and stays there until cleared.
// Revision    : 1.0 - initial release
// ============================================================================
module settle_timer #(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int c_cnt_w = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(SETTLE - 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_expired) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/gate_truth_table_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : gate_truth_table_sequencer
// Description : Sweeps a gate-under-test through all input vectors, captures
//               its truth table and scores it against a latched expectation.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_truth_table_sequencer
    import tt_seq_defs::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [combos(N_IN)-1:0]     expected,
    input  logic                        s_in,
    output logic [N_IN-1:0]             drv,
    output logic                        busy,
    output logic                        done,
    output logic [combos(N_IN)-1:0]     table_out,
    output logic [N_IN:0]               err_count,
    output logic                        match
);

    localparam int                c_combos   = combos(N_IN);
    localparam logic [N_IN-1:0]   c_last_idx = '1;

    logic [1:0]            r_state;
    logic [N_IN-1:0]       r_idx;
    logic [N_IN-1:0]       r_drv;
    logic [c_combos-1:0]   r_exp_q;
    logic [c_combos-1:0]   r_table;
    logic [N_IN:0]         r_err;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_match;

    logic                  w_start_ok;
    logic                  w_tmr_clr;
    logic                  w_tmr_en;
    logic                  w_expired;
    logic                  w_bad;
    logic [N_IN:0]         w_err_next;

    assign w_start_ok = (r_state == c_st_idle) && start;
    assign w_tmr_clr  = w_start_ok || (r_state == c_st_sample);
    assign w_tmr_en   = (r_state == c_st_settle);
    assign w_bad      = (s_in != r_exp_q[r_idx]);
    assign w_err_next = r_err + {{N_IN{1'b0}}, w_bad};

    settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .clk       (clk),
        .rst       (reset),
        .i_clr     (w_tmr_clr),
        .i_en      (w_tmr_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_idx   <= '0;
            r_drv   <= '0;
            r_exp_q <= '0;
            r_table <= '0;
            r_err   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_match <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_exp_q <= expected;
                        r_idx   <= '0;
                        r_drv   <= '0;
                        r_table <= '0;
                        r_err   <= '0;
                        r_match <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= c_st_settle;
                    end
                end
                c_st_settle: begin
                    if (w_expired) begin
                        r_state <= c_st_sample;
                    end
                end
                c_st_sample: begin
                    r_table[r_idx] <= s_in;
                    r_err          <= w_err_next;
                    if (r_idx == c_last_idx) begin
                        // Score from the final count so match is valid alongside done.
                        r_match <= (w_err_next == '0);
                        r_done  <= 1'b1;
                        r_state <= c_st_done;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_drv   <= r_idx + 1'b1;
                        r_state <= c_st_settle;
                    end
                end
                c_st_done: begin
                    r_busy  <= 1'b0;
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign drv       = r_drv;
    assign busy      = r_busy;
    assign done      = r_done;
    assign table_out = r_table;
    assign err_count = r_err;
    assign match     = r_match;

endmodule
`default_nettype wire

// File: tb/tb_gate_truth_table_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_truth_table_sequencer
// Description : Directed bench for two sequencer configurations (2-in/settle 2
//               and 3-in/settle 1) driving behavioural gates.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_truth_table_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] gate_mode = 2'd0;

    logic       start_a = 1'b0;
    logic [3:0] exp_a   = 4'b0;
    logic       s_in_a;
    logic [1:0] drv_a;
    logic       busy_a, done_a, match_a;
    logic [3:0] tab_a;
    logic [2:0] err_a;

    logic       start_b = 1'b0;
    logic [7:0] exp_b   = 8'b0;
    logic       s_in_b;
    logic [2:0] drv_b;
    logic       busy_b, done_b, match_b;
    logic [7:0] tab_b;
    logic [3:0] err_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Gate-under-test models: 0 = NOR, 1 = stuck at 0, 2 = OR.
    assign s_in_a = (gate_mode == 2'd0) ? ~|drv_a :
                    (gate_mode == 2'd2) ?  |drv_a : 1'b0;
    assign s_in_b = &drv_b;

    gate_truth_table_sequencer #(.N_IN(2), .SETTLE(2)) u_dut_a (
        .clk       (clk),
        .reset     (reset),
        .start     (start_a),
        .expected  (exp_a),
        .s_in      (s_in_a),
        .drv       (drv_a),
        .busy      (busy_a),
        .done      (done_a),
        .table_out (tab_a),
        .err_count (err_a),
        .match     (match_a)
    );

    gate_truth_table_sequencer #(.N_IN(3), .SETTLE(1)) u_dut_b (
        .clk       (clk),
        .reset     (reset),
        .start     (start_b),
        .expected  (exp_b),
        .s_in      (s_in_b),
        .drv       (drv_b),
        .busy      (busy_b),
        .done      (done_b),
        .table_out (tab_b),
        .err_count (err_b),
        .match     (match_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full sweep; cycle 0 is the cycle right after the start-capturing edge.
    task automatic sweep(input int which, input logic [7:0] exp_tab, input int per,
                         input int ncomb, input bit poke, input logic [7:0] want_tab,
                         input logic [3:0] want_err, input logic want_match);
        int total;
        int first_done;
        int done_cnt;
        logic [2:0] d;
        logic       bz, dn, mt;
        logic [7:0] tb;
        logic [3:0] er;
        total      = ncomb * per;
        first_done = -1;
        done_cnt   = 0;
        if (which == 0) begin
            exp_a   = exp_tab[3:0];
            start_a = 1'b1;
        end else begin
            exp_b   = exp_tab;
            start_b = 1'b1;
        end
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
        for (int cyc = 0; cyc <= total + 3; cyc++) begin
            if (cyc > 0) tick();
            if (poke && cyc == 3) begin
                start_a = 1'b1;
                exp_a   = 4'b1111;
            end
            if (poke && cyc == 4) start_a = 1'b0;
            if (which == 0) begin
                d = {1'b0, drv_a}; bz = busy_a; dn = done_a; mt = match_a;
                tb = {4'b0, tab_a}; er = {1'b0, err_a};
            end else begin
                d = drv_b; bz = busy_b; dn = done_b; mt = match_b;
                tb = tab_b; er = err_b;
            end
            if (dn) begin
                done_cnt++;
                if (first_done < 0) first_done = cyc;
            end
            if (cyc < total) begin
                chk("drv_vector", {29'b0, d}, cyc / per);
                chk("busy_in_sweep", {31'b0, bz}, 32'd1);
            end
            if (cyc == total) begin
                chk("busy_at_done", {31'b0, bz}, 32'd1);
                chk("table_out", {24'b0, tb}, {24'b0, want_tab});
                chk("err_count", {28'b0, er}, {28'b0, want_err});
                chk("match", {31'b0, mt}, {31'b0, want_match});
            end
            if (cyc == total + 1) chk("busy_after_done", {31'b0, bz}, 32'd0);
            if (cyc == total + 3) chk("table_held", {24'b0, tb}, {24'b0, want_tab});
        end
        chk("done_cycle", first_done, total);
        chk("done_pulses", done_cnt, 32'd1);
    endtask

    initial begin
        int dn_seen;
        repeat (3) tick();
        chk("rst_busy_a", {31'b0, busy_a}, 32'd0);
        chk("rst_done_a", {31'b0, done_a}, 32'd0);
        chk("rst_drv_a", {30'b0, drv_a}, 32'd0);
        chk("rst_table_a", {28'b0, tab_a}, 32'd0);
        chk("rst_err_a", {29'b0, err_a}, 32'd0);
        chk("rst_match_a", {31'b0, match_a}, 32'd0);
        chk("rst_busy_b", {31'b0, busy_b}, 32'd0);
        chk("rst_table_b", {24'b0, tab_b}, 32'd0);
        reset = 1'b0;
        tick();

        // NOR gate, matching expectation
        gate_mode = 2'd0;
        sweep(0, 8'h01, 3, 4, 1'b0, 8'h01, 4'd0, 1'b1);
        // Stuck-at-0 gate
        gate_mode = 2'd1;
        sweep(0, 8'h01, 3, 4, 1'b0, 8'h00, 4'd1, 1'b0);
        // OR gate against NOR expectation
        gate_mode = 2'd2;
        sweep(0, 8'h01, 3, 4, 1'b0, 8'h0E, 4'd4, 1'b0);
        // start re-asserted and expected changed mid-sweep
        gate_mode = 2'd0;
        sweep(0, 8'h01, 3, 4, 1'b1, 8'h01, 4'd0, 1'b1);

        // Reset mid-sweep
        exp_a   = 4'b0001;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (4) tick();
        chk("table_pre_reset", {28'b0, tab_a}, 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", {31'b0, busy_a}, 32'd0);
        chk("abort_drv", {30'b0, drv_a}, 32'd0);
        chk("abort_table", {28'b0, tab_a}, 32'd0);
        chk("abort_err", {29'b0, err_a}, 32'd0);
        chk("abort_done", {31'b0, done_a}, 32'd0);
        dn_seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done_a) dn_seen++;
        end
        chk("abort_no_done", dn_seen, 32'd0);
        sweep(0, 8'h01, 3, 4, 1'b0, 8'h01, 4'd0, 1'b1);

        // AND3 on the 3-input / settle-1 instance
        sweep(1, 8'h80, 2, 8, 1'b0, 8'h80, 4'd0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
